// File: rtl/tri_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tri_scan_gen
// Purpose  : Clips a triangle's bounding box to the screen and streams its
//            pixel centres in raster order. Build option: WINDING_FIX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tri_scan_gen #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tri_valid,
  output logic             o_tri_ready,
  input  logic [WIDTH-1:0] i_x0,
  input  logic [WIDTH-1:0] i_y0,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_y1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_y2,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  output logic [WIDTH-1:0] o_px,
  output logic [WIDTH-1:0] o_py,
  output logic [WIDTH-1:0] o_x0,
  output logic [WIDTH-1:0] o_y0,
  output logic [WIDTH-1:0] o_x1,
  output logic [WIDTH-1:0] o_y1,
  output logic [WIDTH-1:0] o_x2,
  output logic [WIDTH-1:0] o_y2,
  output logic             o_first,
  output logic             o_last,
  output logic             o_done,
  output logic             o_busy
);

  localparam int c_CW = WIDTH - FRAC;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_CLIP  = 3'd2;
  localparam logic [2:0] c_SCAN  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic signed [c_CW-1:0] c_ZERO = '0;
  localparam logic signed [c_CW-1:0] c_ONE  = c_CW'(1);
  localparam logic signed [c_CW-1:0] c_XLIM = c_CW'(SCREEN_W - 1);
  localparam logic signed [c_CW-1:0] c_YLIM = c_CW'(SCREEN_H - 1);
  localparam logic [FRAC-1:0]        c_HALF = {1'b1, {(FRAC-1){1'b0}}};

  logic [2:0] r_state;
  logic [2:0] w_next;

  logic signed [WIDTH-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic signed [c_CW-1:0]  r_xmin, r_xmax, r_ymin, r_ymax;
  logic signed [c_CW-1:0]  r_cx, r_cy;
  logic                    r_first;

  logic signed [c_CW-1:0]  w_fx0, w_fy0, w_fx1, w_fy1, w_fx2, w_fy2;
  logic signed [c_CW-1:0]  w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
  logic                    w_accept;
  logic                    w_empty;
  logic                    w_last;
  logic                    w_swap;
  logic                    w_degen;

  function automatic logic signed [c_CW-1:0] f_min3(
    input logic signed [c_CW-1:0] a,
    input logic signed [c_CW-1:0] b,
    input logic signed [c_CW-1:0] c
  );
    logic signed [c_CW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [c_CW-1:0] f_max3(
    input logic signed [c_CW-1:0] a,
    input logic signed [c_CW-1:0] b,
    input logic signed [c_CW-1:0] c
  );
    logic signed [c_CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // floor is monotonic, so min/max of the floored vertices equals floor of min/max
  assign w_fx0 = r_x0[WIDTH-1:FRAC];
  assign w_fy0 = r_y0[WIDTH-1:FRAC];
  assign w_fx1 = r_x1[WIDTH-1:FRAC];
  assign w_fy1 = r_y1[WIDTH-1:FRAC];
  assign w_fx2 = r_x2[WIDTH-1:FRAC];
  assign w_fy2 = r_y2[WIDTH-1:FRAC];

  assign w_xmin_c = (r_xmin < c_ZERO) ? c_ZERO : r_xmin;
  assign w_xmax_c = (r_xmax > c_XLIM) ? c_XLIM : r_xmax;
  assign w_ymin_c = (r_ymin < c_ZERO) ? c_ZERO : r_ymin;
  assign w_ymax_c = (r_ymax > c_YLIM) ? c_YLIM : r_ymax;

  assign w_accept = (r_state == c_IDLE) && i_tri_valid;
  assign w_empty  = (w_xmin_c > w_xmax_c) || (w_ymin_c > w_ymax_c) || w_degen;
  assign w_last   = (r_cx == r_xmax) && (r_cy == r_ymax);

`ifdef WINDING_FIX_EN
  localparam int c_PW = 2 * WIDTH + 3;

  logic signed [WIDTH:0]  w_dx1, w_dy1, w_dx2, w_dy2;
  logic signed [c_PW-1:0] w_area;
  logic                   r_swap;
  logic                   r_degen;

  function automatic logic signed [c_PW-1:0] f_sx(input logic signed [WIDTH:0] v);
    return {{(c_PW-WIDTH-1){v[WIDTH]}}, v};
  endfunction

  assign w_dx1  = {r_x1[WIDTH-1], r_x1} - {r_x0[WIDTH-1], r_x0};
  assign w_dy1  = {r_y1[WIDTH-1], r_y1} - {r_y0[WIDTH-1], r_y0};
  assign w_dx2  = {r_x2[WIDTH-1], r_x2} - {r_x0[WIDTH-1], r_x0};
  assign w_dy2  = {r_y2[WIDTH-1], r_y2} - {r_y0[WIDTH-1], r_y0};
  assign w_area = f_sx(w_dx1) * f_sx(w_dy2) - f_sx(w_dy1) * f_sx(w_dx2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_swap  <= 1'b0;
      r_degen <= 1'b0;
    end else if (w_accept) begin
      r_swap  <= 1'b0;
      r_degen <= 1'b0;
    end else if (r_state == c_SETUP) begin
      r_swap  <= w_area[c_PW-1];
      r_degen <= (w_area == '0);
    end
  end

  assign w_swap  = r_swap;
  assign w_degen = r_degen;
`else
  assign w_swap  = 1'b0;
  assign w_degen = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (i_tri_valid) w_next = c_SETUP;
      c_SETUP: w_next = c_CLIP;
      c_CLIP:  w_next = w_empty ? c_DONE : c_SCAN;
      c_SCAN:  if (i_pix_ready && w_last) w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_tri_ready = 1'b0;
    o_pix_valid = 1'b0;
    o_first     = 1'b0;
    o_last      = 1'b0;
    o_done      = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      c_IDLE: begin
        o_tri_ready = 1'b1;
        o_busy      = 1'b0;
      end
      c_SCAN: begin
        o_pix_valid = 1'b1;
        o_first     = r_first;
        o_last      = w_last;
      end
      c_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_px = (r_state == c_SCAN) ? {r_cx, c_HALF} : '0;
  assign o_py = (r_state == c_SCAN) ? {r_cy, c_HALF} : '0;
  assign o_x0 = r_x0;
  assign o_y0 = r_y0;
  assign o_x1 = w_swap ? r_x2 : r_x1;
  assign o_y1 = w_swap ? r_y2 : r_y1;
  assign o_x2 = w_swap ? r_x1 : r_x2;
  assign o_y2 = w_swap ? r_y1 : r_y2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_y2    <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_tri_valid) begin
            r_x0 <= i_x0;
            r_y0 <= i_y0;
            r_x1 <= i_x1;
            r_y1 <= i_y1;
            r_x2 <= i_x2;
            r_y2 <= i_y2;
          end
        end
        c_SETUP: begin
          r_xmin <= f_min3(w_fx0, w_fx1, w_fx2);
          r_xmax <= f_max3(w_fx0, w_fx1, w_fx2);
          r_ymin <= f_min3(w_fy0, w_fy1, w_fy2);
          r_ymax <= f_max3(w_fy0, w_fy1, w_fy2);
        end
        c_CLIP: begin
          r_xmin  <= w_xmin_c;
          r_xmax  <= w_xmax_c;
          r_ymin  <= w_ymin_c;
          r_ymax  <= w_ymax_c;
          r_cx    <= w_xmin_c;
          r_cy    <= w_ymin_c;
          r_first <= 1'b1;
        end
        c_SCAN: begin
          if (i_pix_ready) begin
            r_first <= 1'b0;
            if (r_cx == r_xmax) begin
              r_cx <= r_xmin;
              r_cy <= r_cy + c_ONE;
            end else begin
              r_cx <= r_cx + c_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_scan_gen
// Purpose  : Scoreboard bench for tri_scan_gen (reference raster model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_scan_gen;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] py;
    logic             first;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tri_valid = 1'b0;
  logic pix_ready = 1'b1;
  logic [WIDTH-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic tri_ready, pix_valid, first, last, done, busy;
  logic [WIDTH-1:0] px, py, ox0, oy0, ox1, oy1, ox2, oy2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int rdy_mode = 0;
  int pcnt     = 0;
  logic [3:0] pat = 4'b1001;

  beat_t q_exp[$];
  logic [WIDTH-1:0] e_x0, e_y0, e_x1, e_y1, e_x2, e_y2;

  logic  prev_stall = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  tri_scan_gen #(
    .WIDTH(WIDTH), .FRAC(FRAC), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_tri_valid(tri_valid), .o_tri_ready(tri_ready),
    .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
    .o_px(px), .o_py(py),
    .o_x0(ox0), .o_y0(oy0), .o_x1(ox1), .o_y1(oy1), .o_x2(ox2), .o_y2(oy2),
    .o_first(first), .o_last(last), .o_done(done), .o_busy(busy)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Reference model: bounding box, clip, raster walk.
  task automatic push_tri(input int vx0, input int vy0, input int vx1, input int vy1,
                          input int vx2, input int vy2, output int npix);
    int xmn, xmx, ymn, ymx;
    bit swap, degen;
    longint a;
    beat_t b;
    a = (longint'(vx1) - longint'(vx0)) * (longint'(vy2) - longint'(vy0))
      - (longint'(vy1) - longint'(vy0)) * (longint'(vx2) - longint'(vx0));
    swap  = 1'b0;
    degen = 1'b0;
`ifdef WINDING_FIX_EN
    swap  = (a < 0);
    degen = (a == 0);
`endif
    e_x0 = vx0; e_y0 = vy0;
    e_x1 = swap ? vx2 : vx1; e_y1 = swap ? vy2 : vy1;
    e_x2 = swap ? vx1 : vx2; e_y2 = swap ? vy1 : vy2;
    xmn = imin3(vx0 >>> FRAC, vx1 >>> FRAC, vx2 >>> FRAC);
    xmx = imax3(vx0 >>> FRAC, vx1 >>> FRAC, vx2 >>> FRAC);
    ymn = imin3(vy0 >>> FRAC, vy1 >>> FRAC, vy2 >>> FRAC);
    ymx = imax3(vy0 >>> FRAC, vy1 >>> FRAC, vy2 >>> FRAC);
    if (xmn < 0) xmn = 0;
    if (ymn < 0) ymn = 0;
    if (xmx > SCREEN_W - 1) xmx = SCREEN_W - 1;
    if (ymx > SCREEN_H - 1) ymx = SCREEN_H - 1;
    npix = 0;
    if (!degen && xmn <= xmx && ymn <= ymx) begin
      for (int yy = ymn; yy <= ymx; yy++) begin
        for (int xx = xmn; xx <= xmx; xx++) begin
          b.px    = (xx <<< FRAC) + (1 << (FRAC - 1));
          b.py    = (yy <<< FRAC) + (1 << (FRAC - 1));
          b.first = (xx == xmn) && (yy == ymn);
          b.last  = (xx == xmx) && (yy == ymx);
          q_exp.push_back(b);
          npix++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    pcnt = pcnt + 1;
    pix_ready = (rdy_mode == 0) ? 1'b1 : pat[pcnt % 4];
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (prev_stall)
        check_eq("stall_hold", {pix_valid, px, py, first, last},
                 {1'b1, held.px, held.py, held.first, held.last});
      if (pix_valid && pix_ready) begin
        if (q_exp.size() == 0) begin
          check_eq("extra_beat", {px, py}, 0);
        end else begin
          e = q_exp.pop_front();
          check_eq("beat", {px, py, first, last}, e);
          check_eq("verts", {ox0, oy0, ox1, oy1, ox2, oy2}, {e_x0, e_y0, e_x1, e_y1, e_x2, e_y2});
        end
        n_beats++;
      end
      prev_stall = pix_valid && !pix_ready;
      held.px = px; held.py = py; held.first = first; held.last = last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_tri(input int vx0, input int vy0, input int vx1, input int vy1,
                           input int vx2, input int vy2);
    @(posedge clk); #1;
    tri_valid = 1'b1;
    x0 = vx0; y0 = vy0; x1 = vx1; y1 = vy1; x2 = vx2; y2 = vy2;
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input string tag, input int vx0, input int vy0, input int vx1,
                         input int vy1, input int vx2, input int vy2, input int mode);
    int npix, base, k;
    bit seen;
    push_tri(vx0, vy0, vx1, vy1, vx2, vy2, npix);
    rdy_mode = mode;
    base = n_beats;
    drive_tri(vx0, vy0, vx1, vy1, vx2, vy2);
    @(negedge clk);
    check_eq({tag, "_setup"}, {pix_valid, busy, tri_ready, done}, 4'b0100);
    @(negedge clk);
    check_eq({tag, "_clip"}, {pix_valid, busy, tri_ready, done}, 4'b0100);
    @(negedge clk);
    check_eq({tag, "_lat"}, {pix_valid, done}, (npix > 0) ? 2'b10 : 2'b01);
    k = 3;
    seen = (npix == 0);
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, seen, 1'b1);
    if (mode == 0 && npix > 0) check_eq({tag, "_done_cycle"}, k, 3 + npix);
    check_eq({tag, "_count"}, n_beats - base, npix);
    check_eq({tag, "_q_empty"}, q_exp.size(), 0);
    @(negedge clk);
    check_eq({tag, "_idle"}, {done, tri_ready, busy}, 3'b010);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npix, base, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctrl", {tri_ready, pix_valid, first, last, done, busy}, 6'b100000);
    check_eq("rst_coord", {px, py, ox0, oy1, ox2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_tri("basic", 32'h20000, 32'h10000, 32'h58000, 32'h10000, 32'h20000, 32'h34000, 0);
    run_tri("clip", -32'h30000, -32'h30000, 32'h10000, -32'h30000, -32'h30000, 32'h10000, 0);
    run_tri("offscr", 32'h2800000, 32'h0A0000, 32'h2BC0000, 32'h0A0000, 32'h28A0000, 32'h140000, 0);
    run_tri("bp", 32'h20000, 32'h10000, 32'h58000, 32'h10000, 32'h20000, 32'h34000, 1);
    run_tri("corner", 32'h2768000, 32'h1D68000, 32'h2BC0000, 32'h1D68000, 32'h2768000, 32'h1F40000, 0);
    run_tri("single", 32'h34000, 32'h44000, 32'h3C000, 32'h48000, 32'h38000, 32'h4C000, 0);
    run_tri("wind", 0, 0, 0, 32'h40000, 32'h40000, 0, 0);
    run_tri("collin", 0, 0, 32'h10000, 32'h10000, 32'h20000, 32'h20000, 1);

    // Abort a scan after its fifth beat with a reset.
    push_tri(32'h20000, 32'h10000, 32'h58000, 32'h10000, 32'h20000, 32'h34000, npix);
    rdy_mode = 0;
    base = n_beats;
    drive_tri(32'h20000, 32'h10000, 32'h58000, 32'h10000, 32'h20000, 32'h34000);
    k = 0;
    while ((n_beats - base) < 5 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("rst_reach5", n_beats - base, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_abort", {pix_valid, busy, tri_ready, done}, 4'b0010);
    q_exp.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_no_done", {pix_valid, busy, tri_ready, done}, 4'b0010);
    run_tri("after_rst", -32'h30000, -32'h30000, 32'h10000, -32'h30000, -32'h30000, 32'h10000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
